usr_tx_ctrl: RTL and testbench
==============================

// Module: usr_tx_ctrl
// PURPOSE
//  UART transmit controller built on the universal-shift-register datapath.
//  Sequences the 2-bit mode select (hold/shift-right/shift-left/load) of a frame-wide USR.
//  Loads a start/data/parity/stop frame on a valid/ready handshake.
//  Shifts the frame out LSB-first, one bit per BAUD_DIV clocks, on serial line tx.
// PARAMETERS
//  DATA_W     8    data bits per frame
//  BAUD_DIV   868  clocks per bit (100 MHz / 115200); legal range >= 2
//  PARITY_EN  0    1 = append a parity bit after the data bits
//  PARITY_ODD 0    1 = odd parity, 0 = even; ignored when PARITY_EN=0
//  FRAME_W is derived, not a parameter: DATA_W + 2 + PARITY_EN
// PORTS
//  clk       in   1       system clock, rising edge
//  reset_n   in   1       asynchronous active-low reset
//  tx_data   in   DATA_W  byte to send; sampled on handshake
//  tx_valid  in   1       source has data; hold data stable until accepted
//  tx_ready  out  1       controller can accept; high only in IDLE
//  tx        out  1       serial line, idles high
//  busy      out  1       frame in progress
//  mode      out  2       current USR mode select, driven for observability
// BEHAVIOUR
//  Mode encoding: 00 HOLD, 01 SHR (shift toward bit 0, fill 1 at MSB), 10 SHL, 11 LOAD.
//   - SHL is never issued by this controller.
//  Reset (async, reset_n=0): state=IDLE, sr=all 1s, baud_cnt=0, bit_cnt=0.
//   - Outputs under reset: tx=1, tx_ready=1, busy=0, mode=00.
//   - Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
//  tx = sr[0], registered; no combinational path from any input to tx.
//  IDLE
//   - tx_ready=1, busy=0.
//   - Handshake = tx_valid & tx_ready: mode=11 that cycle.
//   - Next edge: sr <= {1'b1, [parity], tx_data, 1'b0}; state <= SEND; counters cleared.
//   - Without a handshake, mode=00.
//  SEND
//   - tx_ready=0, busy=1.
//   - baud_cnt counts 0..BAUD_DIV-1.
//   - At baud_cnt==BAUD_DIV-1: mode=01 (shift), bit_cnt++, baud_cnt wraps to 0. Otherwise mode=00.
//   - At that tick with bit_cnt==FRAME_W-1: stop bit has completed -> state <= IDLE.
//  Timing
//   - Start bit appears on tx on the clock edge after the handshake.
//   - Each bit lasts exactly BAUD_DIV clocks; a frame lasts FRAME_W*BAUD_DIV clocks.
//   - Back-to-back frames: exactly one idle-high clock between the stop bit and the next start bit.
//  Parity
//   - Even: ^tx_data. Odd: ~^tx_data.
//   - Computed from tx_data at handshake time.
//  tx_valid while busy is ignored (no accept, no error); source keeps it asserted.
//  Counter widths: $clog2(BAUD_DIV), $clog2(FRAME_W+1). No wrap beyond terminal counts.
// STRUCTURE
//  Shared package usr_pkg:
//   - MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD (2-bit localparams).
//   - FSM state encoding for IDLE and SEND.
//  Sub-module usr_bit_cell:
//   - One async-reset (to 1) flop plus the 4:1 mode-select mux.
//   - Inputs: hold/right/left/load candidates and mode.
//   - Instantiated FRAME_W times in a generate loop; this module keeps the FSM, counters and parity.
// TESTING (bench uses BAUD_DIV=4, DATA_W=8)
//  1 Idle after reset: reset_n low 3 clk, release -> tx=1, tx_ready=1, busy=0, mode=00 held 20 clk.
//  2 Basic frame, PARITY_EN=0: send 8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clk.
//    - busy for 40 clk; tx_ready back high on clk 41.
//  3 Even parity, PARITY_EN=1: send 8'h07 -> parity bit=1, 11-bit frame, 44 clk.
//    - Repeat with PARITY_ODD=1 -> parity bit=0.
//  4 Source hold-off: tx_valid high with 8'h3C throughout an 8'hA5 frame.
//    - Single accept, only after the stop bit; exactly 1 idle-high clk before the second start bit.
//  5 Mid-frame reset: pulse reset_n low during data bit 3 (async, off clock edge).
//    - tx=1 and busy=0 immediately; the next frame sent after release is bit-exact.
//  6 Mode trace check on every frame:
//    - mode=11 exactly once (handshake cycle); mode=01 exactly FRAME_W times.
//    - mode never equals 10 (assertion).

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register UART transmitter:
// USR mode-select encoding and the controller state encoding.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a flop that resets to 1 and a
// 4:1 mux choosing hold / shift-right / shift-left / load by mode.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hold_d,
    input  logic       right_d,
    input  logic       left_d,
    input  logic       load_d,
    input  logic [1:0] mode,
    output logic       q
);

    // NOTE: sequential state is assigned with <= so all cells sample their
    // neighbours' old values on the same edge, which is what makes it shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b1;
        end else begin
            case (mode)
                MODE_SHR:  q <= right_d;
                MODE_SHL:  q <= left_d;
                MODE_LOAD: q <= load_d;
                default:   q <= hold_d;
            endcase
        end
    end

endmodule

// File: rtl/usr_tx_ctrl.sv
// UART transmit controller: loads a start/data/[parity]/stop frame into a
// frame-wide universal shift register and shifts it out LSB-first on tx.
module usr_tx_ctrl
    import usr_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 868,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic [1:0]        mode
);

    localparam int FRAME_W = DATA_W + 2 + PARITY_EN;
    localparam int BAUD_W  = $clog2(BAUD_DIV);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

    tx_state_e          state;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] sr;
    logic [FRAME_W-1:0] load_frame;
    logic [FRAME_W-1:0] shr_src;
    logic [FRAME_W-1:0] shl_src;
    logic               handshake;
    logic               baud_tick;

    assign tx_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_SEND);
    assign handshake = tx_valid & tx_ready;
    assign baud_tick = busy && (baud_cnt == BAUD_LAST);
    assign tx        = sr[0];

    // Shifting fills with 1 so the line falls back to idle-high after the stop bit.
    assign shr_src = {1'b1, sr[FRAME_W-1:1]};
    assign shl_src = {sr[FRAME_W-2:0], 1'b1};

    generate
        if (PARITY_EN != 0) begin : g_parity
            logic par_bit;
            assign par_bit    = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
            assign load_frame = {1'b1, par_bit, tx_data, 1'b0};
        end else begin : g_no_parity
            assign load_frame = {1'b1, tx_data, 1'b0};
        end
    endgenerate

    always_comb begin
        mode = MODE_HOLD;
        if (handshake) begin
            mode = MODE_LOAD;
        end else if (baud_tick) begin
            mode = MODE_SHR;
        end
    end

    for (genvar i = 0; i < FRAME_W; i++) begin : g_cell
        usr_bit_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .hold_d  (sr[i]),
            .right_d (shr_src[i]),
            .left_d  (shl_src[i]),
            .load_d  (load_frame[i]),
            .mode    (mode),
            .q       (sr[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        state    <= ST_SEND;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_SEND: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        // The tick that ends the stop bit returns to IDLE.
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_tx_ctrl.sv
// Bench for usr_tx_ctrl: three instances (no parity, even, odd) at BAUD_DIV=4,
// checked cycle by cycle against a frame-bit model built from the line format.
module tb_usr_tx_ctrl;
    import usr_pkg::*;

    localparam int BAUD = 4;

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data [3];
    logic       tx_valid[3];
    logic       tx_ready[3];
    logic       tx      [3];
    logic       busy    [3];
    logic [1:0] mode    [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    usr_tx_ctrl #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]), .mode(mode[0]));
    usr_tx_ctrl #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]), .mode(mode[1]));
    usr_tx_ctrl #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2]), .mode(mode[2]));

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            assert (mode[u] != MODE_SHL) else $error("FAIL mode_shl: unit %0d issued mode 10", u);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected line bits for one frame: start, data LSB first, parity, stop.
    function automatic bitq_t frame_bits(input int u, input logic [7:0] d);
        bitq_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (u == 1) q.push_back(bit'(ones % 2 == 1));
        if (u == 2) q.push_back(bit'(ones % 2 == 0));
        q.push_back(1'b1);
        return q;
    endfunction

    task automatic check_idle_all(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                check($sformatf("idle_tx u%0d", u),    32'(tx[u]),       32'd1);
                check($sformatf("idle_ready u%0d", u), 32'(tx_ready[u]), 32'd1);
                check($sformatf("idle_busy u%0d", u),  32'(busy[u]),     32'd0);
                check($sformatf("idle_mode u%0d", u),  32'(mode[u]),     32'(MODE_HOLD));
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a clock edge with unit u idle. Returns just after the
    // edge that ends the stop bit, or right after an abort reset.
    task automatic frame(input int u, input logic [7:0] d, input bit keep,
                         input logic [7:0] nxt, input int abort_at);
        bitq_t bits;
        int    n;
        int    n_load = 0;
        int    n_shr  = 0;
        bits = frame_bits(u, d);
        n    = bits.size() * BAUD;
        tx_data[u]  = d;
        tx_valid[u] = 1'b1;
        @(negedge clk);
        check($sformatf("hs_ready u%0d", u), 32'(tx_ready[u]), 32'd1);
        check($sformatf("hs_tx u%0d", u),    32'(tx[u]),       32'd1);
        check($sformatf("hs_mode u%0d", u),  32'(mode[u]),     32'(MODE_LOAD));
        if (mode[u] == MODE_LOAD) n_load++;
        @(posedge clk);
        #1;
        if (keep) tx_data[u] = nxt;
        else      tx_valid[u] = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst_tx",    32'(tx[u]),       32'd1);
                check("rst_busy",  32'(busy[u]),     32'd0);
                check("rst_ready", 32'(tx_ready[u]), 32'd1);
                check("rst_mode",  32'(mode[u]),     32'(MODE_HOLD));
                return;
            end
            check($sformatf("tx u%0d d%02h bit%0d", u, d, k / BAUD), 32'(tx[u]), 32'(bits[k / BAUD]));
            check($sformatf("busy u%0d", u),  32'(busy[u]),     32'd1);
            check($sformatf("ready u%0d", u), 32'(tx_ready[u]), 32'd0);
            check($sformatf("mode u%0d k%0d", u, k), 32'(mode[u]),
                  (k % BAUD == BAUD - 1) ? 32'(MODE_SHR) : 32'(MODE_HOLD));
            if (mode[u] == MODE_LOAD) n_load++;
            if (mode[u] == MODE_SHR)  n_shr++;
            @(posedge clk);
            #1;
        end
        check($sformatf("load_count u%0d", u), 32'(n_load), 32'd1);
        check($sformatf("shr_count u%0d", u),  32'(n_shr),  32'(bits.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            tx_data[u]  = 8'h00;
            tx_valid[u] = 1'b0;
        end

        // Idle after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("in_rst_tx u%0d", u),    32'(tx[u]),       32'd1);
            check($sformatf("in_rst_ready u%0d", u), 32'(tx_ready[u]), 32'd1);
            check($sformatf("in_rst_busy u%0d", u),  32'(busy[u]),     32'd0);
            check($sformatf("in_rst_mode u%0d", u),  32'(mode[u]),     32'(MODE_HOLD));
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        check_idle_all(20);

        // Basic frame and parity variants
        frame(0, 8'hA5, 1'b0, 8'h00, -1);
        check_idle_all(2);
        frame(1, 8'h07, 1'b0, 8'h00, -1);
        check_idle_all(1);
        frame(2, 8'h07, 1'b0, 8'h00, -1);
        check_idle_all(1);

        // Source hold-off: next byte waits for the stop bit, one idle clock
        frame(0, 8'hA5, 1'b1, 8'h3C, -1);
        frame(0, 8'h3C, 1'b0, 8'h00, -1);
        check_idle_all(2);

        // Mid-frame reset during data bit 3
        frame(0, 8'h5A, 1'b0, 8'h00, 4 * BAUD + 1);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_all(2);
        frame(0, 8'h5A, 1'b0, 8'h00, -1);
        check_idle_all(1);

        // Randomized frames, some back-to-back
        for (int i = 0; i < 16; i++) begin
            int         u;
            logic [7:0] d;
            logic [7:0] nxt;
            u   = int'($urandom_range(0, 2));
            d   = 8'($urandom);
            nxt = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                frame(u, d, 1'b1, nxt, -1);
                frame(u, nxt, 1'b0, 8'h00, -1);
            end else begin
                frame(u, d, 1'b0, 8'h00, -1);
            end
            check_idle_all(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
